// File: rtl/conv3x3_bn_core.sv
// 3x3 convolution core with batch-norm: fetches one kernel + BN pair per output
// channel, then streams pixel windows through a 3-stage MAC/BN pipeline.
module conv3x3_bn_core #(
  parameter int DW   = 32,
  parameter int FRAC = 16,
  parameter int CNTW = 16
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNTW-1:0]   nch,
  input  logic [CNTW-1:0]   npix,
  output logic              busy,
  output logic              done,
  input  logic              w_ready,
  output logic              w_next,
  input  logic [9*DW-1:0]   w_data,
  input  logic [DW-1:0]     w_bn0,
  input  logic [DW-1:0]     w_bn1,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [9*DW-1:0]   pix_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [2:0]        state_dbg
);
  localparam int PW = DW + FRAC;
  localparam int SW = PW + 4;
  localparam int MW = SW + DW;
  localparam logic signed [MW-1:0] YMAX = MW'({1'b0, {(DW-1){1'b1}}});
  localparam logic signed [MW-1:0] YMIN = -YMAX - 1;

  typedef enum logic [2:0] {IDLE, WFETCH, WACK, RUN, DRAIN} state_t;
  state_t state, state_n;

  logic [CNTW-1:0]        nch_r, npix_r, ch_cnt, pix_cnt;
  logic [9*DW-1:0]        k_r;
  logic signed [DW-1:0]   bn0_r, bn1_r;
  logic                   en, accept, pipe_empty, last_ch, done_n, w_next_n;
  logic                   v1, v2;
  logic signed [2*DW-1:0] prod [9];
  logic signed [PW-1:0]   p_c [9];
  logic signed [PW-1:0]   p1 [9];
  logic signed [SW-1:0]   s_c, s2;
  logic signed [MW-1:0]   m_c, y_c;
  logic [DW-1:0]          sat_c;

  // Handshakes: a transfer happens on a clock edge where valid && ready are both high.
  assign en         = !(out_valid && !out_ready);
  assign pix_ready  = (state == RUN) && en && (pix_cnt < npix_r);
  assign accept     = pix_valid && pix_ready;
  assign pipe_empty = !v1 && !v2 && !out_valid;
  assign last_ch    = (ch_cnt + 1'b1) == nch_r;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_comb begin
    state_n  = state;
    done_n   = 1'b0;
    w_next_n = w_next;
    case (state)
      IDLE: if (start) begin
        if (nch == '0) done_n = 1'b1;
        else           state_n = WFETCH;
      end
      WFETCH: if (w_ready) begin
        w_next_n = 1'b1;
        state_n  = WACK;
      end
      WACK: if (!w_ready) begin
        w_next_n = 1'b0;
        state_n  = RUN;
      end
      RUN: if (pix_cnt >= npix_r) state_n = DRAIN;
      DRAIN: if (pipe_empty) begin
        if (last_ch) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = WFETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      w_next  <= 1'b0;
      nch_r   <= '0;
      npix_r  <= '0;
      ch_cnt  <= '0;
      pix_cnt <= '0;
      k_r     <= '0;
      bn0_r   <= '0;
      bn1_r   <= '0;
    end else begin
      state  <= state_n;
      done   <= done_n;
      w_next <= w_next_n;
      if (state == IDLE && start) begin
        nch_r  <= nch;
        npix_r <= npix;
        ch_cnt <= '0;
      end
      // Weights only load here, so in-flight windows always see their own kernel.
      if (state == WFETCH && w_ready) begin
        k_r   <= w_data;
        bn0_r <= w_bn0;
        bn1_r <= w_bn1;
      end
      if (state == WACK && !w_ready) pix_cnt <= '0;
      if (accept) pix_cnt <= pix_cnt + 1'b1;
      if (state == DRAIN && pipe_empty) ch_cnt <= ch_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      prod[i] = $signed(pix_data[i*DW +: DW]) * $signed(k_r[i*DW +: DW]);
      p_c[i]  = PW'(prod[i] >>> FRAC);
    end
  end

  always_comb begin
    s_c = '0;
    for (int i = 0; i < 9; i++) s_c = s_c + SW'(p1[i]);
  end

  always_comb begin
    m_c = MW'(s2) * MW'(bn0_r);
    y_c = (m_c >>> FRAC) + MW'(bn1_r);
    if (y_c > YMAX)      sat_c = {1'b0, {(DW-1){1'b1}}};
    else if (y_c < YMIN) sat_c = {1'b1, {(DW-1){1'b0}}};
    else                 sat_c = y_c[DW-1:0];
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      s2        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < 9; i++) p1[i] <= '0;
    end else if (en) begin
      v1 <= accept;
      for (int i = 0; i < 9; i++) p1[i] <= p_c[i];
      v2        <= v1;
      s2        <= s_c;
      out_valid <= v2;
      if (v2) out_data <= sat_c;
    end
  end
endmodule

// File: doc/conv3x3_bn_core.md
Name: conv3x3_bn_core

Overview:
- Downstream consumer of the weight-read stage. Per output channel, it latches one 3x3 kernel (9 words) and one batch-norm pair (bn0 = scale, bn1 = offset) through the ready/next weight handshake.
- It then streams NPIX 3x3 pixel windows through a 3-stage fixed-point MAC + BN pipeline and emits one result word per window on a valid/ready output stream.
- It repeats for NCH channels, then pulses done.

Parameters:
- DW, 32, data/weight word width (signed two's complement)
- FRAC, 16, fractional bits of the Q format used by pixels, weights, bn0, bn1 and the result
- CNTW, 16, width of the channel and pixel counters

Ports:
- aclk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- nch  in  CNTW  number of output channels; sampled on start; 0 means done immediately
- npix  in  CNTW  windows per channel; sampled on start; 0 means no windows for the channel (weights still fetched)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last channel completes
- w_ready  in  1  weight set valid, from weight reader
- w_next  out  1  request for the next weight set; level held until w_ready falls
- w_data  in  9*DW  kernel, packed as {k22,k21,k20,k12,k11,k10,k02,k01,k00}, with k00 in bits [DW-1:0]
- w_bn0  in  DW  BN scale
- w_bn1  in  DW  BN offset
- pix_valid  in  1  window valid
- pix_ready  out  1  window accepted when pix_valid && pix_ready
- pix_data  in  9*DW  window, same packing as w_data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  DW  result

Behaviour:
- Reset values:
  - FSM enters IDLE.
  - busy, done, w_next, pix_ready and out_valid are 0; out_data is 0.
  - Pipeline valids, counters and the weight/BN registers are cleared.
- Reset mid-operation aborts immediately. No done pulse is issued, and w_next drops in the same reset cycle.
- FSM states:
  - IDLE: on start, latch nch/npix and clear ch_cnt. If nch==0, pulse done next cycle and stay in IDLE; otherwise go to WFETCH.
  - WFETCH: wait for w_ready==1. On the first cycle w_ready is seen high, register w_data, w_bn0 and w_bn1 into local registers, raise w_next, and go to WACK.
  - WACK: hold w_next=1 until w_ready==0, then drop w_next on the next cycle and go to RUN with pix_cnt=0.
  - RUN: pix_ready = en && (pix_cnt<npix). Each accepted window increments pix_cnt. When pix_cnt reaches npix (immediately if npix==0), go to DRAIN.
  - DRAIN: wait until all pipeline valids are 0. Then increment ch_cnt. If ch_cnt+1==nch, pulse done and go to IDLE; otherwise go to WFETCH.
- The weight registers change only in WFETCH, so a kernel never changes while a window of the previous channel is still in flight.
- A start pulse outside IDLE is ignored.
- Pipeline and stall rules:
  - Stall signal: en = !(out_valid && !out_ready). Every stage advances only when en=1, including while out_valid=0.
  - S1: p_i = (pix_i * k_i) >>> FRAC, computed as a 2*DW signed product with arithmetic shift (truncation toward minus infinity). Keep DW+FRAC bits.
  - S2: s = sum of the nine p_i, with DW+FRAC+4 bits of headroom so the sum cannot overflow.
  - S3: y = ((s * bn0) >>> FRAC) + bn1, computed at full width, then saturated to signed DW: values above the maximum give 0x7FFF..F, values below the minimum give 0x800..0.
- Latency is 3 cycles from the accepting edge to out_valid, with no stall. Throughput is 1 window per cycle.
- out_data and out_valid are registered outputs of S3. out_data holds stable while out_valid && !out_ready.
- With out_ready tied 1, no window is ever dropped or duplicated.
- Simultaneous events: acceptance in S1 and output of S3 in the same cycle are both legal. Output order equals input order.

Test Plan:
- FRAC=16, nch=1, npix=1:
  - Stimulus: all k=0x00010000, bn0=0x00020000, bn1=0xFFFF0000, window all 0x00010000.
  - Response: out_data=0x00110000 (17.0) exactly 3 cycles after acceptance, then done pulses once.
- Weight handshake, with the reader model asserting w_ready 5 cycles after w_next falls:
  - Response: w_next rises 1 cycle after w_ready, holds until w_ready=0, and pix_ready stays 0 throughout.
  - For nch=3, exactly 3 w_next pulses and 3 distinct kernels are used.
- Saturation:
  - Window all 0x7FFFFFFF with k=1.0 and bn0=1.0, bn1=0 gives 0x7FFFFFFF.
  - Window all 0x80000000 with the same weights gives 0x80000000.
  - k=-1.0 on a positive window gives the expected negative sum, computed bit-exact against a reference model.
- Backpressure with npix=64 random windows and out_ready toggling 1 low / 2 high:
  - Output sequence matches the golden model, with no loss or duplication.
  - out_data stays stable while stalled.
  - done arrives only after the 64th output is accepted.
- Boundaries:
  - nch=0 gives done 1 cycle after start, with no w_next.
  - npix=0 with nch=2 fetches 2 weight sets, produces 0 outputs, then done.
  - A start pulse while busy is ignored.
- Reset asserted mid-RUN with 2 windows in flight:
  - Next cycle: out_valid=0, w_next=0, busy=0, no done.
  - A subsequent start runs cleanly.
